elastic_pipe_reg: RTL and testbench

ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

---
 rtl/elastic_pipe_reg.sv | 119 +++++++++++
 tb/tb_elastic_pipe_reg.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: DEPTH valid/data stages with a combinational
// ready chain, so bubbles collapse and a full pipe can pass through one
// word per cycle. Global enable freezes everything; clr flushes synchronously;
// r resets asynchronously.

module elastic_pipe_stage #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             r,
    input  logic             clr,
    input  logic             load,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    // Load valid every time the stage advances; data only when a real word
    // arrives, so a bubble leaves the previous data in place.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else if (clr) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else if (load) begin
            v <= v_in;
            if (v_in) d <= d_in;
        end
    end

endmodule

module elastic_pipe_reg #(
    parameter int                 WIDTH     = 8,
    parameter int                 DEPTH     = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       r,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            vld_pipe;
    logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;
    logic [DEPTH-1:0]            stg_v_in;
    logic [DEPTH-1:0][WIDTH-1:0] stg_d_in;
    logic [DEPTH:0]              rdy;
    logic                        in_xfer;
    logic                        out_xfer;

    // Ready ripples back from the output: a stage can take a word if it is
    // empty or the stage ahead of it is also moving.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int k = DEPTH-1; k >= 0; k--)
            rdy[k] = ~vld_pipe[k] | rdy[k+1];
    end

    assign in_ready  = en & ~clr & rdy[0];
    assign out_valid = en & vld_pipe[DEPTH-1];
    assign out_data  = dat_pipe[DEPTH-1];
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign stg_v_in[g] = in_valid;
            assign stg_d_in[g] = in_data;
        end else begin : g_body
            assign stg_v_in[g] = vld_pipe[g-1];
            assign stg_d_in[g] = dat_pipe[g-1];
        end

        elastic_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk  (clk),
            .r    (r),
            .clr  (clr),
            .load (en & rdy[g]),
            .v_in (stg_v_in[g]),
            .d_in (stg_d_in[g]),
            .v    (vld_pipe[g]),
            .d    (dat_pipe[g])
        );
    end

    // Occupancy tracks accepted minus delivered words; both at once cancel.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg (WIDTH=8, DEPTH=3): directed scenarios with
// literal expectations, then random traffic, all shadowed by a position-based
// queue model compared on every falling edge.

module tb_elastic_pipe_reg;

    localparam int          WIDTH = 8;
    localparam int          DEPTH = 3;
    localparam logic [7:0]  RV    = 8'h00;

    logic       clk = 1'b0;
    logic       r = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    elastic_pipe_reg #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .r         (r),
        .en        (en),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of words in arrival order, each with its stage position.
    typedef struct {
        logic [7:0] d;
        int         p;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] m_last = RV;
    bit         m_acc;
    int         m_lim;

    function automatic logic m_in_ready();
        return en && !clr && (mq.size() < DEPTH || out_ready);
    endfunction

    function automatic logic m_out_valid();
        return en && mq.size() > 0 && mq[0].p == DEPTH-1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge r);
            if (r || clr) begin
                mq.delete();
                m_last = RV;
            end else if (en) begin
                m_acc = in_valid && m_in_ready();
                if (mq.size() > 0 && mq[0].p == DEPTH-1 && out_ready)
                    void'(mq.pop_front());
                for (int i = 0; i < mq.size(); i++) begin
                    m_lim = (i == 0) ? DEPTH : mq[i-1].p;
                    if (mq[i].p + 1 < m_lim) begin
                        mq[i].p = mq[i].p + 1;
                        if (mq[i].p == DEPTH-1) m_last = mq[i].d;
                    end
                end
                if (m_acc) begin
                    mq.push_back('{d: in_data, p: 0});
                    if (DEPTH == 1) m_last = in_data;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("m_in_ready",  {31'd0, in_ready},  {31'd0, m_in_ready()});
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_out_valid()});
            chk("m_count",     {30'd0, count},     mq.size());
            chk("m_out_data",  {24'd0, out_data},  {24'd0, m_last});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic c, input logic iv,
                         input logic [7:0] id, input logic ordy);
        en = e; clr = c; in_valid = iv; in_data = id; out_ready = ordy;
    endtask

    initial begin
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_count",     {30'd0, count},     0);
        chk("rst_out_data",  {24'd0, out_data},  {24'd0, RV});
        #11 r = 1'b0;
        step();

        // Streaming 0x01..0x0A
        drive(1, 0, 1, 8'h00, 1);
        for (int i = 1; i <= 10; i++) begin
            in_data = 8'(i);
            step();
            if (i >= 3) begin
                chk("s1_data",  {24'd0, out_data},  i-2);
                chk("s1_valid", {31'd0, out_valid}, 1);
                chk("s1_count", {30'd0, count},     3);
            end else begin
                chk("s1_novalid", {31'd0, out_valid}, 0);
            end
        end
        in_valid = 1'b0;
        step(); chk("s1_drain9",  {24'd0, out_data}, 9);  chk("s1_cnt2", {30'd0, count}, 2);
        step(); chk("s1_drain10", {24'd0, out_data}, 10); chk("s1_cnt1", {30'd0, count}, 1);
        step(); chk("s1_empty",   {31'd0, out_valid}, 0); chk("s1_cnt0", {30'd0, count}, 0);

        // Backpressure
        drive(1, 0, 1, 8'hA1, 0); step();
        in_data = 8'hA2; step();
        in_data = 8'hA3; step();
        chk("s2_count",  {30'd0, count},     3);
        chk("s2_data",   {24'd0, out_data},  8'hA1);
        chk("s2_valid",  {31'd0, out_valid}, 1);
        in_data = 8'hEE;
        chk("s2_notrdy", {31'd0, in_ready},  0);
        step(); step();
        chk("s2_hold",   {24'd0, out_data},  8'hA1);
        chk("s2_hcnt",   {30'd0, count},     3);
        drive(1, 0, 1, 8'hA4, 1);
        #1 chk("s2_passrdy", {31'd0, in_ready}, 1);
        step();
        chk("s2_pass_data", {24'd0, out_data}, 8'hA2);
        chk("s2_pass_cnt",  {30'd0, count},    3);
        drive(1, 0, 0, 8'h00, 1);
        step(); chk("s2_d3", {24'd0, out_data}, 8'hA3);
        step(); chk("s2_d4", {24'd0, out_data}, 8'hA4);
        step(); chk("s2_empty", {30'd0, count}, 0);

        // Bubble collapse
        drive(1, 0, 1, 8'h55, 0); step();
        in_valid = 1'b0;
        chk("s3_e1", {31'd0, out_valid}, 0);
        step(); chk("s3_e2", {31'd0, out_valid}, 0);
        step(); chk("s3_e3", {31'd0, out_valid}, 1);
        chk("s3_data", {24'd0, out_data}, 8'h55);
        drive(1, 0, 1, 8'h66, 0); step();
        in_data = 8'h77; step();
        chk("s3_count", {30'd0, count}, 3);
        in_data = 8'h88;
        #1 chk("s3_full_notrdy", {31'd0, in_ready}, 0);
        drive(1, 0, 0, 8'h00, 1);
        step(); chk("s3_d66", {24'd0, out_data}, 8'h66);
        step(); chk("s3_d77", {24'd0, out_data}, 8'h77);
        step(); chk("s3_empty", {30'd0, count}, 0);

        // Freeze
        drive(1, 0, 1, 8'h10, 1); step();
        in_data = 8'h11; step();
        in_data = 8'h12; step();
        chk("s4_pre", {24'd0, out_data}, 8'h10);
        drive(0, 0, 1, 8'h13, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s4_frz_rdy",  {31'd0, in_ready},  0);
            chk("s4_frz_vld",  {31'd0, out_valid}, 0);
            chk("s4_frz_cnt",  {30'd0, count},     3);
            chk("s4_frz_data", {24'd0, out_data},  8'h10);
        end
        en = 1'b1; step(); chk("s4_r11", {24'd0, out_data}, 8'h11);
        in_data = 8'h14; step(); chk("s4_r12", {24'd0, out_data}, 8'h12);
        in_valid = 1'b0; step(); chk("s4_r13", {24'd0, out_data}, 8'h13);
        step(); chk("s4_r14", {24'd0, out_data}, 8'h14);
        step(); chk("s4_empty", {30'd0, count}, 0);

        // Clear with traffic on both sides
        drive(1, 0, 1, 8'h21, 0); step();
        in_data = 8'h22; step();
        chk("s5_cnt2", {30'd0, count}, 2);
        drive(1, 1, 1, 8'h23, 1);
        #1 chk("s5_clr_notrdy", {31'd0, in_ready}, 0);
        step();
        drive(1, 0, 0, 8'h00, 0);
        chk("s5_cnt",   {30'd0, count},     0);
        chk("s5_vld",   {31'd0, out_valid}, 0);
        chk("s5_data",  {24'd0, out_data},  {24'd0, RV});
        step();
        chk("s5_noacc", {30'd0, count},     0);

        // Async reset mid-cycle with a full pipe
        drive(1, 0, 1, 8'h31, 0); step();
        in_data = 8'h32; step();
        in_data = 8'h33; step();
        in_valid = 1'b0;
        chk("s6_full", {30'd0, count}, 3);
        #1 r = 1'b1;
        #1;
        chk("s6_rst_vld",  {31'd0, out_valid}, 0);
        chk("s6_rst_cnt",  {30'd0, count},     0);
        chk("s6_rst_data", {24'd0, out_data},  {24'd0, RV});
        r = 1'b0;
        drive(1, 0, 1, 8'h40, 1);
        #1 chk("s6_rdy", {31'd0, in_ready}, 1);
        step(); in_valid = 1'b0;
        chk("s6_l1", {31'd0, out_valid}, 0);
        step(); chk("s6_l2", {31'd0, out_valid}, 0);
        step(); chk("s6_l3", {31'd0, out_valid}, 1);
        chk("s6_l3d", {24'd0, out_data}, 8'h40);
        step();

        // Random traffic, model-checked on every falling edge
        for (int i = 0; i < 600; i++) begin
            r         = ($urandom_range(99) == 0);
            en        = ($urandom_range(9) != 0);
            clr       = ($urandom_range(29) == 0);
            in_valid  = ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) < 6);
            in_data   = 8'($urandom);
            step();
        end
        drive(1, 0, 0, 8'h00, 1);
        r = 1'b0;
        step(); step(); step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
